// File: rtl/video_decode_pkg.sv
// Shared types for the video decode slice: pixel record, FSM states,
// default frame-boundary blank length and small decode helpers.
package video_decode_pkg;

  localparam int unsigned VBLANK_MIN_DEFAULT = 1024;
  localparam logic [8:0]  COORD_MAX          = 9'd511;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_VBLANK,
    ST_ACTIVE,
    ST_HBLANK
  } state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic        shadow;
    logic [8:0]  x;
    logic [8:0]  y;
    logic        sof;
    logic        eol;
  } pixel_t;

  localparam int unsigned PIXEL_W = $bits(pixel_t);

  // Rebuild the palette word from the DAC-ordered colour buses.
  function automatic logic [15:0] decode_pc(input logic [6:0] r,
                                            input logic [6:0] g,
                                            input logic [6:0] b);
    return {r[0], r[1], g[1], b[1], r[5:2], g[5:2], b[5:2]};
  endfunction

  // Coordinate increment that sticks at the top of the 9-bit range.
  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == COORD_MAX) ? v : v + 9'd1;
  endfunction

endpackage

// File: rtl/video_decode_fifo.sv
// First-word-fall-through output buffer for decoded pixel records.
// A push into a full buffer is accepted only when a pop happens in the
// same cycle; otherwise it is ignored and the contents stay unchanged.
// An empty buffer presents an all-zero head.
module video_decode_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 8
) (
  input  logic             CLK_6MB,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge CLK_6MB) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since an empty head reads as zero.
  always_ff @(posedge CLK_6MB) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/video_decode.sv
// Video decode: samples the DAC-ordered colour buses and blanking,
// tracks frame/line structure, tags each active pixel with X/Y/SOF/EOL
// and buffers the records for a ready/valid consumer.
// Optional build macro: VIDEO_DECODE_CHECK_EN enables the sticky
// ERR_MISMATCH consistency check; without it the flag is tied low.
module video_decode
  import video_decode_pkg::*;
#(
  parameter int unsigned VBLANK_MIN = VBLANK_MIN_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLK_6MB,
  input  logic        RESET,
  input  logic        nBNKB,
  input  logic [6:0]  VIDEO_R,
  input  logic [6:0]  VIDEO_G,
  input  logic [6:0]  VIDEO_B,
  input  logic        PIX_READY,
  output logic        PIX_VALID,
  output logic [15:0] PIX_PC,
  output logic        PIX_SHADOW,
  output logic [8:0]  PIX_X,
  output logic [8:0]  PIX_Y,
  output logic        PIX_SOF,
  output logic        PIX_EOL,
  output logic        ERR_MISMATCH,
  output logic        OVERFLOW
);

  localparam int unsigned     CNT_W    = $clog2(VBLANK_MIN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(VBLANK_MIN);

  logic             s1_active;
  logic [6:0]       s1_r;
  logic [6:0]       s1_g;
  logic [6:0]       s1_b;

  state_t           state;
  logic [CNT_W-1:0] blank_cnt;
  logic [CNT_W-1:0] blank_cnt_nxt;
  logic             blank_done;
  logic [8:0]       x_cnt;
  logic [8:0]       y_cnt;

  logic             s2_valid;
  pixel_t           s2_pix;
  pixel_t           pix_new;
  pixel_t           push_rec;
  pixel_t           head;

  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             overflow_q;

  // S1: register blanking and colour every cycle.
  always_ff @(posedge CLK_6MB) begin
    if (RESET) begin
      s1_active <= 1'b0;
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
    end else begin
      s1_active <= nBNKB;
      s1_r      <= VIDEO_R;
      s1_g      <= VIDEO_G;
      s1_b      <= VIDEO_B;
    end
  end

  // Blank run length: cleared by any active sample, sticks at VBLANK_MIN.
  always_comb begin
    blank_cnt_nxt = blank_cnt;
    if (s1_active) begin
      blank_cnt_nxt = '0;
    end else if (blank_cnt != CNT_FULL) begin
      blank_cnt_nxt = blank_cnt + CNT_W'(1);
    end
    blank_done = !s1_active && (blank_cnt_nxt == CNT_FULL);
  end

  // Record for the S1 sample, as it would be emitted in the current state.
  always_comb begin
    pix_new        = '0;
    pix_new.pc     = decode_pc(s1_r, s1_g, s1_b);
    pix_new.shadow = s1_r[6];
    pix_new.x      = (state == ST_ACTIVE) ? sat_inc9(x_cnt) : '0;
    pix_new.y      = (state == ST_VBLANK) ? '0 : y_cnt;
    pix_new.sof    = (state == ST_VBLANK);
    pix_new.eol    = 1'b0;
  end

  // Frame/line tracker; loads S2 with each accepted active pixel.
  always_ff @(posedge CLK_6MB) begin
    if (RESET) begin
      state     <= ST_SYNC;
      blank_cnt <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      s2_valid  <= 1'b0;
      s2_pix    <= '0;
    end else begin
      blank_cnt <= blank_cnt_nxt;
      s2_valid  <= 1'b0;
      s2_pix    <= pix_new;
      case (state)
        ST_SYNC: begin
          if (blank_done) state <= ST_VBLANK;
        end
        ST_VBLANK: begin
          if (s1_active) begin
            state    <= ST_ACTIVE;
            x_cnt    <= '0;
            y_cnt    <= '0;
            s2_valid <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (s1_active) begin
            x_cnt    <= pix_new.x;
            s2_valid <= 1'b1;
          end else begin
            state <= ST_HBLANK;
            y_cnt <= sat_inc9(y_cnt);
          end
        end
        ST_HBLANK: begin
          if (s1_active) begin
            state    <= ST_ACTIVE;
            x_cnt    <= '0;
            s2_valid <= 1'b1;
          end else if (blank_done) begin
            state <= ST_VBLANK;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

  // S2 is held one cycle so the sample now in S1 decides end-of-line.
  always_comb begin
    push_rec     = s2_pix;
    push_rec.eol = !s1_active;
  end

  assign pop = PIX_VALID && PIX_READY;

  video_decode_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (PIXEL_W)
  ) u_fifo (
    .CLK_6MB (CLK_6MB),
    .RESET   (RESET),
    .push    (s2_valid),
    .pop     (pop),
    .din     (push_rec),
    .dout    (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Sticky overflow: a pixel was dropped because the buffer was full.
  always_ff @(posedge CLK_6MB) begin
    if (RESET) begin
      overflow_q <= 1'b0;
    end else if (s2_valid && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  assign PIX_VALID  = !fifo_empty;
  assign PIX_PC     = head.pc;
  assign PIX_SHADOW = head.shadow;
  assign PIX_X      = head.x;
  assign PIX_Y      = head.y;
  assign PIX_SOF    = head.sof;
  assign PIX_EOL    = head.eol;
  assign OVERFLOW   = overflow_q;

`ifdef VIDEO_DECODE_CHECK_EN
  logic err_q;
  logic sample_bad;

  // Active: shadow and dark bits must agree across channels; blank: all zero.
  always_comb begin
    if (s1_active) begin
      sample_bad = !((s1_r[6] == s1_g[6]) && (s1_g[6] == s1_b[6])) ||
                   !((s1_r[0] == s1_g[0]) && (s1_g[0] == s1_b[0]));
    end else begin
      sample_bad = |{s1_r, s1_g, s1_b};
    end
  end

  // Sticky mismatch flag, cleared only by reset.
  always_ff @(posedge CLK_6MB) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else if (sample_bad) begin
      err_q <= 1'b1;
    end
  end

  assign ERR_MISMATCH = err_q;
`else
  logic unused_check_bits;
  assign unused_check_bits = ^{s1_g[6], s1_b[6], s1_g[0], s1_b[0]};
  assign ERR_MISMATCH      = 1'b0;
`endif

endmodule

// File: tb/tb_video_decode.sv
// Scoreboard bench for video_decode: expected records are queued as
// pixels are driven and compared as the DUT hands them out.
module tb_video_decode;

  localparam int unsigned VBM = 1024;

  typedef struct packed {
    logic [15:0] pc;
    logic        shadow;
    logic [8:0]  x;
    logic [8:0]  y;
    logic        sof;
    logic        eol;
  } exp_t;

  logic        CLK_6MB = 1'b0;
  logic        RESET   = 1'b1;
  logic        nBNKB   = 1'b0;
  logic [6:0]  VIDEO_R = '0;
  logic [6:0]  VIDEO_G = '0;
  logic [6:0]  VIDEO_B = '0;
  logic        PIX_READY = 1'b1;
  logic        PIX_VALID;
  logic [15:0] PIX_PC;
  logic        PIX_SHADOW;
  logic [8:0]  PIX_X;
  logic [8:0]  PIX_Y;
  logic        PIX_SOF;
  logic        PIX_EOL;
  logic        ERR_MISMATCH;
  logic        OVERFLOW;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned pops     = 0;
  int unsigned cyc      = 0;
  int unsigned lat_start = 0;
  bit          lat_armed = 1'b0;
  exp_t        q[$];

  video_decode #(
    .VBLANK_MIN (VBM),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK_6MB      (CLK_6MB),
    .RESET        (RESET),
    .nBNKB        (nBNKB),
    .VIDEO_R      (VIDEO_R),
    .VIDEO_G      (VIDEO_G),
    .VIDEO_B      (VIDEO_B),
    .PIX_READY    (PIX_READY),
    .PIX_VALID    (PIX_VALID),
    .PIX_PC       (PIX_PC),
    .PIX_SHADOW   (PIX_SHADOW),
    .PIX_X        (PIX_X),
    .PIX_Y        (PIX_Y),
    .PIX_SOF      (PIX_SOF),
    .PIX_EOL      (PIX_EOL),
    .ERR_MISMATCH (ERR_MISMATCH),
    .OVERFLOW     (OVERFLOW)
  );

  always #5 CLK_6MB = ~CLK_6MB;

  always @(posedge CLK_6MB) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pc(input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
    logic [15:0] pc;
    pc        = '0;
    pc[15]    = r[0];
    pc[14]    = r[1];
    pc[13]    = g[1];
    pc[12]    = b[1];
    pc[11:8]  = r[5:2];
    pc[7:4]   = g[5:2];
    pc[3:0]   = b[5:2];
    return pc;
  endfunction

  // Colour patterns: 0 fixed reference, 1 random consistent, 2 ramp, 3 shadow-only red.
  function automatic logic [20:0] pick(input int unsigned mode, input int unsigned i);
    logic       s, d;
    logic [6:0] r, g, b;
    case (mode)
      0: begin r = 7'b1011010; g = 7'b1011010; b = 7'b1011010; end
      1: begin
        s = 1'($urandom_range(0, 1));
        d = 1'($urandom_range(0, 1));
        r = {s, 4'($urandom), 1'($urandom), d};
        g = {s, 4'($urandom), 1'($urandom), d};
        b = {s, 4'($urandom), 1'($urandom), d};
      end
      2: begin
        r = {1'b0, 4'(i), 1'b1, 1'b0};
        g = {1'b0, 4'(i + 3), 1'b0, 1'b0};
        b = {1'b0, 4'(15 - i), 1'b1, 1'b0};
      end
      default: begin r = 7'h40; g = 7'h00; b = 7'h00; end
    endcase
    return {r, g, b};
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge CLK_6MB);
      #1;
    end
  endtask

  task automatic blank(input int unsigned n);
    nBNKB   = 1'b0;
    VIDEO_R = '0;
    VIDEO_G = '0;
    VIDEO_B = '0;
    tick(n);
  endtask

  // Drives n pixels; the first `keep` are expected to come out.
  task automatic send_line(input int unsigned n, input int unsigned y, input bit sof,
                           input int unsigned keep, input int unsigned mode, input bit arm);
    logic [20:0] c;
    exp_t        e;
    for (int unsigned i = 0; i < n; i++) begin
      c       = pick(mode, i);
      nBNKB   = 1'b1;
      VIDEO_R = c[20:14];
      VIDEO_G = c[13:7];
      VIDEO_B = c[6:0];
      if (i < keep) begin
        e.pc     = model_pc(c[20:14], c[13:7], c[6:0]);
        e.shadow = c[20];
        e.x      = 9'(i);
        e.y      = 9'(y);
        e.sof    = sof && (i == 0);
        e.eol    = (i == n - 1);
        q.push_back(e);
      end
      if (arm && i == 0) begin
        lat_start = cyc;
        lat_armed = 1'b1;
      end
      tick(1);
      if (mode == 2 && i == 5) check("ovf_before_drop", 32'(OVERFLOW), 32'd0);
      if (mode == 2 && i == 6) check("ovf_after_drop", 32'(OVERFLOW), 32'd1);
    end
    blank(1);
  endtask

  task automatic wait_drain();
    for (int unsigned i = 0; i < 40 && (q.size() != 0 || PIX_VALID); i++) tick(1);
    check("drain_q", 32'(q.size()), 32'd0);
    check("drain_valid", 32'(PIX_VALID), 32'd0);
    check("lat_seen", 32'(lat_armed), 32'd0);
    lat_armed = 1'b0;
  endtask

  task automatic check_idle();
    check("idle_valid", 32'(PIX_VALID), 32'd0);
    check("idle_sof", 32'(PIX_SOF), 32'd0);
    check("idle_eol", 32'(PIX_EOL), 32'd0);
    check("idle_err", 32'(ERR_MISMATCH), 32'd0);
    check("idle_ovf", 32'(OVERFLOW), 32'd0);
    check("idle_pc", 32'(PIX_PC), 32'd0);
    check("idle_shadow", 32'(PIX_SHADOW), 32'd0);
    check("idle_x", 32'(PIX_X), 32'd0);
    check("idle_y", 32'(PIX_Y), 32'd0);
  endtask

  // Output monitor: sampled mid-cycle, a handshake here pops at the next edge.
  always @(negedge CLK_6MB) begin
    exp_t e;
    if (!RESET && PIX_VALID) begin
      if (lat_armed) begin
        check("latency", cyc - lat_start, 32'd3);
        lat_armed = 1'b0;
      end
      if (PIX_READY) begin
        if (q.size() == 0) begin
          check("unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          pops++;
          check("pc", 32'(PIX_PC), 32'(e.pc));
          check("shadow", 32'(PIX_SHADOW), 32'(e.shadow));
          check("x", 32'(PIX_X), 32'(e.x));
          check("y", 32'(PIX_Y), 32'(e.y));
          check("sof", 32'(PIX_SOF), 32'(e.sof));
          check("eol", 32'(PIX_EOL), 32'(e.eol));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned pops_before;
    logic        err_exp;
`ifdef VIDEO_DECODE_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif

    // Reset state, during and after reset.
    tick(1);
    check_idle();
    tick(2);
    RESET = 1'b0;
    tick(1);
    check_idle();
    blank(VBM - 1);

    // Reference line: 320 pixels, first line of the frame.
    send_line(320, 0, 1'b1, 320, 0, 1'b1);
    blank(64);

    // Second line after a short gap: Y=1, no SOF.
    send_line(40, 1, 1'b0, 40, 1, 1'b1);
    wait_drain();
    check("err_clean", 32'(ERR_MISMATCH), 32'd0);

    // Stalled consumer: only the first four of ten pixels survive.
    PIX_READY = 1'b0;
    blank(20);
    pops_before = pops;
    send_line(10, 2, 1'b0, 4, 2, 1'b0);
    blank(8);
    check("ovf_set", 32'(OVERFLOW), 32'd1);
    check("held_valid", 32'(PIX_VALID), 32'd1);
    check("held_x", 32'(PIX_X), 32'd0);
    PIX_READY = 1'b1;
    wait_drain();
    check("stall_pops", pops - pops_before, 32'd4);
    check("ovf_sticky", 32'(OVERFLOW), 32'd1);

    // Channel disagreement on shadow bit.
    send_line(1, 3, 1'b0, 1, 3, 1'b1);
    blank(4);
    check("err_set", 32'(ERR_MISMATCH), 32'(err_exp));
    wait_drain();
    blank(10);
    check("err_sticky", 32'(ERR_MISMATCH), 32'(err_exp));

    // Reset in the middle of a line, then resync on the next frame.
    send_line(100, 4, 1'b0, 100, 1, 1'b0);
    nBNKB   = 1'b1;
    VIDEO_R = 7'h2A;
    VIDEO_G = 7'h2A;
    VIDEO_B = 7'h2A;
    RESET   = 1'b1;
    tick(1);
    q.delete();
    check_idle();
    RESET = 1'b0;
    send_line(219, 0, 1'b0, 0, 1, 1'b0);
    check("post_rst_quiet", 32'(PIX_VALID), 32'd0);
    blank(VBM - 1);
    check("resync_quiet", 32'(PIX_VALID), 32'd0);
    send_line(16, 0, 1'b1, 16, 1, 1'b1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
